// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: digit slot indexes and
// the active-low {g,f,e,d,c,b,a} segment patterns.
package stopwatch_pkg;

  localparam int unsigned NDIG = 6;

  localparam logic [2:0] IDX_HND_0 = 3'd0;
  localparam logic [2:0] IDX_HND_1 = 3'd1;
  localparam logic [2:0] IDX_SEC_0 = 3'd2;
  localparam logic [2:0] IDX_SEC_1 = 3'd3;
  localparam logic [2:0] IDX_MIN_0 = 3'd4;
  localparam logic [2:0] IDX_MIN_1 = 3'd5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Entry n is the pattern for BCD digit n.
  localparam logic [0:9][6:0] SEG_TAB = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/stopwatch_7seg_dec.sv
// BCD to active-low 7-segment decoder; non-BCD codes show a dash so a
// corrupted time value is visible on the display.
module stopwatch_7seg_dec
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    if (bcd <= 4'd9) seg_n = SEG_TAB[bcd];
  end

endmodule

// File: rtl/stopwatch_display.sv
// Six-digit multiplexed 7-segment driver for the stopwatch time interface,
// with per-frame snapshot, anti-ghost blanking, leading-zero blank and hold blink.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int unsigned DPN = 24_000,
  parameter int unsigned BLK = 2,
  parameter int unsigned BPN = 12_000_000,
  parameter bit          BLZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] t_hnd_0,
  input  logic [3:0] t_hnd_1,
  input  logic [3:0] t_sec_0,
  input  logic [3:0] t_sec_1,
  input  logic [3:0] t_min_0,
  input  logic [3:0] t_min_1,
  input  logic       s_run,
  input  logic       s_hld,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] dig_n,
  output logic       led_run,
  output logic       led_hld
);

  localparam int unsigned CW = $clog2(DPN);
  localparam int unsigned BW = $clog2(BPN);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DPN - 1);
  localparam logic [CW-1:0] VIS_LO    = CW'(BLK);
  localparam logic [CW-1:0] VIS_HI    = CW'(DPN - BLK);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BPN - 1);

  logic [NDIG-1:0][3:0] t_all, snap_q, snap_d;
  logic [NDIG-1:0][6:0] seg_all;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic                 boff_q, boff_d;
  logic                 run_q, hld_q;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [5:0]           dig_q, dig_d;
  logic                 wrap, vis;

  always_comb begin
    t_all            = '0;
    t_all[IDX_HND_0] = t_hnd_0;
    t_all[IDX_HND_1] = t_hnd_1;
    t_all[IDX_SEC_0] = t_sec_0;
    t_all[IDX_SEC_1] = t_sec_1;
    t_all[IDX_MIN_0] = t_min_0;
    t_all[IDX_MIN_1] = t_min_1;
  end

  // One decoder per digit lane, all fed from the frame snapshot.
  stopwatch_7seg_dec u_dec [NDIG-1:0] (
    .bcd   (snap_q),
    .seg_n (seg_all)
  );

  always_comb begin
    wrap   = (cnt_q == CNT_LAST);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_MIN_1) ? IDX_HND_0 : idx_q + 3'd1;
      // Capture only at the frame boundary so a frame never mixes two times.
      if (idx_q == IDX_MIN_1) snap_d = t_all;
    end

    bcnt_d = bcnt_q + 1'b1;
    boff_d = boff_q;
    if (s_hld && !hld_q) begin
      bcnt_d = '0;
      boff_d = 1'b0;
    end else if (bcnt_q == BCNT_LAST) begin
      bcnt_d = '0;
      boff_d = !boff_q;
    end

    vis   = (cnt_q >= VIS_LO) && (cnt_q < VIS_HI);
    seg_d = seg_all[idx_q];
    dp_d  = !((idx_q == IDX_SEC_0) || (idx_q == IDX_MIN_0));
    if (BLZ && (idx_q == IDX_MIN_1) && (snap_q[IDX_MIN_1] == 4'd0)) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
    dig_d = '1;
    if (vis && !(hld_q && boff_q)) dig_d[idx_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      idx_q  <= IDX_HND_0;
      snap_q <= '0;
      bcnt_q <= '0;
      boff_q <= 1'b0;
      run_q  <= 1'b0;
      hld_q  <= 1'b0;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      dig_q  <= '1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      bcnt_q <= bcnt_d;
      boff_q <= boff_d;
      run_q  <= s_run;
      hld_q  <= s_hld;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      dig_q  <= dig_d;
    end
  end

  assign seg_n   = seg_q;
  assign dp_n    = dp_q;
  assign dig_n   = dig_q;
  assign led_run = run_q;
  assign led_hld = hld_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display: a cycle-indexed reference model
// pushes expected outputs, a negedge monitor pops and compares (BLZ=1 and BLZ=0 DUTs).
module tb_stopwatch_display;

  localparam int DPN = 8;
  localparam int BLK = 1;
  localparam int BPN = 64;
  localparam int FRM = DPN * 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] t_in [6];
  logic       s_run = 1'b0;
  logic       s_hld = 1'b0;

  logic [6:0] seg1, seg0;
  logic       dp1, dp0, lr1, lr0, lh1, lh0;
  logic [5:0] dig1, dig0;

  stopwatch_display #(.DPN(DPN), .BLK(BLK), .BPN(BPN), .BLZ(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .t_hnd_0(t_in[0]), .t_hnd_1(t_in[1]), .t_sec_0(t_in[2]),
    .t_sec_1(t_in[3]), .t_min_0(t_in[4]), .t_min_1(t_in[5]),
    .s_run(s_run), .s_hld(s_hld),
    .seg_n(seg1), .dp_n(dp1), .dig_n(dig1), .led_run(lr1), .led_hld(lh1)
  );

  stopwatch_display #(.DPN(DPN), .BLK(BLK), .BPN(BPN), .BLZ(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .t_hnd_0(t_in[0]), .t_hnd_1(t_in[1]), .t_sec_0(t_in[2]),
    .t_sec_1(t_in[3]), .t_min_0(t_in[4]), .t_min_1(t_in[5]),
    .s_run(s_run), .s_hld(s_hld),
    .seg_n(seg0), .dp_n(dp0), .dig_n(dig0), .led_run(lr0), .led_hld(lh0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [5:0] dig;
    logic [6:0] seg1;
    logic [6:0] seg0;
    logic       dp;
    logic       lrun;
    logic       lhld;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   gcyc = 0;
  int   errors = 0;
  int   checks = 0;

  // Reference model state: cycles since reset release, displayed frame value,
  // held status seen by the display and the cycle the current hold began.
  int         mc;
  logic [3:0] snap [6];
  logic       prev_hld;
  int         start;

  always @(posedge clk) gcyc <= gcyc + 1;

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    mc = 0;
    for (int i = 0; i < 6; i++) snap[i] = 4'd0;
    prev_hld = 1'b0;
    start = 0;
  endtask

  // Called inside a cycle after inputs are settled: predicts what the DUT
  // shows during the next cycle, then advances to the next cycle.
  task automatic step();
    exp_t e;
    int   pos, slot;
    logic off;
    pos  = mc % DPN;
    slot = (mc / DPN) % 6;
    if (s_hld && !prev_hld) start = mc + 1;
    off = prev_hld && ((((mc - start) / BPN) % 2) == 1);
    e.due  = gcyc + 1;
    e.lrun = s_run;
    e.lhld = s_hld;
    e.dig  = 6'h3F;
    if (pos >= BLK && pos < DPN - BLK && !off) e.dig[slot] = 1'b0;
    e.seg1 = seg_ref(snap[slot]);
    e.seg0 = e.seg1;
    e.dp   = !(slot == 2 || slot == 4);
    if (slot == 5 && snap[5] == 4'd0) e.seg1 = 7'h7F;
    sb.push_back(e);
    if (pos == DPN - 1 && slot == 5)
      for (int i = 0; i < 6; i++) snap[i] = t_in[i];
    prev_hld = s_hld;
    mc++;
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= gcyc) begin
      me = sb.pop_front();
      chk("sb_due", gcyc, me.due);
      chk("dig_n_blz1", {26'd0, dig1}, {26'd0, me.dig});
      chk("dig_n_blz0", {26'd0, dig0}, {26'd0, me.dig});
      chk("led_run", {30'd0, lr1, lr0}, {30'd0, me.lrun, me.lrun});
      chk("led_hld", {30'd0, lh1, lh0}, {30'd0, me.lhld, me.lhld});
      if (me.dig != 6'h3F) begin
        chk("seg_n_blz1", {25'd0, seg1}, {25'd0, me.seg1});
        chk("seg_n_blz0", {25'd0, seg0}, {25'd0, me.seg0});
        chk("dp_n", {30'd0, dp1, dp0}, {30'd0, me.dp, me.dp});
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seg"}, {18'd0, seg1, seg0}, {18'd0, 7'h7F, 7'h7F});
    chk({tag, "_dig"}, {20'd0, dig1, dig0}, {20'd0, 6'h3F, 6'h3F});
    chk({tag, "_dp"},  {30'd0, dp1, dp0},   32'd3);
    chk({tag, "_led"}, {28'd0, lr1, lr0, lh1, lh0}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) t_in[i] = 4'(i + 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();

    // Scan from release, zero snapshot first frame, then 1..6 decode.
    repeat (3 * FRM) step();

    // Mid-frame change must wait for the next frame boundary.
    t_in[0] = 4'd3;
    repeat (FRM + 20) step();
    t_in[0] = 4'd7;
    repeat (2 * FRM) step();

    // Leading zero on ten-minutes and a non-BCD minutes code.
    t_in[5] = 4'd0;
    t_in[4] = 4'hC;
    repeat (2 * FRM) step();

    // Hold blink, release, and a second hold that must restart the phase.
    s_run = 1'b1;
    s_hld = 1'b1;
    repeat (300) step();
    s_hld = 1'b0;
    repeat (60) step();
    s_hld = 1'b1;
    repeat (150) step();
    s_hld = 1'b0;
    s_run = 1'b0;
    repeat (20) step();

    // Randomized input churn.
    repeat (900) begin
      if ($urandom_range(0, 15) == 0)
        t_in[$urandom_range(0, 5)] = ($urandom_range(0, 7) == 0) ?
          4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 31) == 0) s_run = ~s_run;
      if ($urandom_range(0, 199) == 0) s_hld = ~s_hld;
      step();
    end
    s_hld = 1'b0;
    for (int i = 0; i < 6; i++) t_in[i] = 4'($urandom_range(1, 9));
    repeat (FRM) step();

    // Asynchronous reset in slot 3, then restart from slot 0 with zero snapshot.
    for (int k = 0; k < FRM && !(((mc / DPN) % 6) == 3 && (mc % DPN) == 3); k++) step();
    chk("reached_slot3", (mc / DPN) % 6, 3);
    #1;
    rst = 1'b0;
    sb.delete();
    #1;
    chk_reset_vals("async_reset");
    s_run = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    repeat (2 * FRM) step();

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Consumer end of the stopwatch BCD time interface.
- Takes the six BCD digits and the run/hold status from `stopwatch`.
- Drives a 6-digit, common-anode, time-multiplexed 7-segment display and two status LEDs.
- Provides coherent frame snapshots, anti-ghosting blanking, leading-zero blanking and hold blinking.

Parameters:
- DPN, 24_000: digit period in clock cycles (slot length per digit); must be > 2*BLK.
- BLK, 2: blanking cycles at the start and end of each digit slot.
- BPN, 12_000_000: blink half-period in clock cycles while in hold.
- BLZ, 1: 1 blanks a zero ten-minutes digit; 0 always shows it.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- t_hnd_0  input  4  BCD hundredths
- t_hnd_1  input  4  BCD ten hundredths
- t_sec_0  input  4  BCD seconds
- t_sec_1  input  4  BCD ten seconds
- t_min_0  input  4  BCD minutes
- t_min_1  input  4  BCD ten minutes
- s_run  input  1  run status
- s_hld  input  1  hold status
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp_n  output  1  decimal point, active-low
- dig_n  output  6  digit anode enables, active-low, one-hot-low; bit i = digit index i
- led_run  output  1  registered s_run
- led_hld  output  1  registered s_hld

Behaviour:
- Reset values (asynchronous, while rst=0): seg_n=7'h7F, dp_n=1, dig_n=6'h3F, led_*=0, all counters 0, snapshot 0.
- Digit indexes: 0=hnd_0, 1=hnd_1, 2=sec_0, 3=sec_1, 4=min_0, 5=min_1.
- Slot counter `cnt`: counts 0..DPN-1. At DPN-1, `cnt` wraps to 0 and digit index `idx` advances 0→5→0.
- Snapshot: all six digits are captured into shadow registers on the cycle where cnt=DPN-1 and idx=5. The whole next frame uses this one coherent value (no tearing); input changes mid-frame are invisible until the next frame.
- Visibility: the slot is visible when BLK ≤ cnt < DPN-BLK; otherwise dig_n=6'h3F.
- Outputs in visible cycles: dig_n[idx]=0, others 1. All outputs are registered, one cycle after the cnt/idx state that selects them.
- Decoder, active-low {g..a}: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex). Codes 10-15 → 3F (dash, error indication).
- Leading-zero blanking: if BLZ=1 and snapshot min_1==0, slot 5 drives seg_n=7F and dp_n=1, but still enables its anode. No other digit is ever blanked.
- Decimal point: dp_n=0 in slots 2 and 4 (separators, format M M.S S.H H); otherwise 1.
- Blink: free-running counter 0..BPN-1 toggles `phase` at wrap.
  - On a rising edge of registered s_hld, counter=0 and phase=on.
  - While led_hld=1 and phase=off, dig_n=6'h3F.
  - While s_hld=0, blink never suppresses output.
- led_run and led_hld: one-cycle registered copies of s_run and s_hld, applied regardless of the blink phase.
- Reset mid-operation: all state returns immediately to reset values. After release, scanning restarts at idx=0, cnt=0, with snapshot 0: display shows "0.00.00", min_1 blank when BLZ=1, until the first snapshot.
- Counter widths: $clog2(DPN) and $clog2(BPN). No overflow; wrap is only by compare.

Decomposition:
- Shared package `stopwatch_pkg`:
  - digit index constants IDX_HND_0..IDX_MIN_1;
  - SEG_BLANK=7'h7F;
  - SEG_DASH=7'h3F;
  - the 10-entry active-low segment table.
- One combinational sub-module `stopwatch_7seg_dec` (4-bit BCD in, 7-bit seg_n out), using the table with a dash default.

Test Plan:
All scenarios use DPN=8, BLK=1, BPN=64.
1. Reset and scan: hold rst=0 for 3 cycles, then release.
   - Outputs are at reset values during reset.
   - After release, dig_n cycles 3E,3D,3B,37,2F,1F (visible 6 of every 8 cycles), with 3F on cnt=0 and cnt=7.
   - The frame repeats every 48 cycles.
2. Decode and separators: inputs 1,2,3,4,5,6 (hnd_0..min_1).
   - After the first snapshot: slot0 seg_n=79, slot1=24, slot2=30 with dp_n=0, slot3=19, slot4=12 with dp_n=0, slot5=02.
3. Coherence: change t_hnd_0 from 3 to 7 mid-frame.
   - Slot 0 shows 30 until the next frame boundary, then 78.
4. Leading zero and error code:
   - min_1=0, BLZ=1 → slot 5 seg_n=7F with dig_n[5]=0.
   - BLZ=0 → 40.
   - min_0=4'hC → slot 4 seg_n=3F.
5. Hold blink: raise s_hld.
   - led_hld=1 one cycle later.
   - Digits are visible for 64 cycles, all-off for 64 cycles, repeating.
   - Lower s_hld → scanning visible continuously; led_run follows s_run with 1-cycle latency.
6. Reset mid-frame: assert rst at idx=3.
   - dig_n=3F and seg_n=7F asynchronously within the same cycle.
   - After release, scanning restarts at slot 0.
